// File: rtl/gt_touch_pkg.sv
// Shared types and register-map constants for the GT-series touch I2C target.
package gt_touch_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV,
        ST_DEV_ACK,
        ST_AH,
        ST_AH_ACK,
        ST_AL,
        ST_AL_ACK,
        ST_WR,
        ST_WR_ACK,
        ST_RD,
        ST_RD_ACK
    } state_e;

    localparam logic [15:0] REG_PID0   = 16'h8140;
    localparam logic [15:0] REG_STATUS = 16'h814E;
    localparam logic [15:0] REG_P1_XL  = 16'h8150;

    localparam int STATUS_READY = 7;

endpackage

// File: rtl/i2c_line_filter.sv
// Conditions SCL and SDA together: 2-flop synchronizer, FILT_LEN-sample hold filter,
// then SCL edge and START/STOP detection on the filtered lines.
module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_f,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic [1:0]          scl_sync_q, sda_sync_q;
    logic [FILT_LEN-1:0] scl_hist_q, sda_hist_q;
    logic                scl_f_q, scl_f_d, sda_f_q, sda_f_d;
    logic                scl_prev_q, sda_prev_q;

    // A filtered line only moves once FILT_LEN consecutive samples agree.
    always_comb begin
        scl_f_d = scl_f_q;
        sda_f_d = sda_f_q;
        if (&scl_hist_q)       scl_f_d = 1'b1;
        else if (~|scl_hist_q) scl_f_d = 1'b0;
        if (&sda_hist_q)       sda_f_d = 1'b1;
        else if (~|sda_hist_q) sda_f_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= '1;
            sda_hist_q <= '1;
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_hist_q <= {scl_hist_q[FILT_LEN-2:0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[FILT_LEN-2:0], sda_sync_q[1]};
            scl_f_q    <= scl_f_d;
            sda_f_q    <= sda_f_d;
            scl_prev_q <= scl_f_q;
            sda_prev_q <= sda_f_q;
        end
    end

    assign sda_f     = sda_f_q;
    assign scl_rise  = scl_f_q & ~scl_prev_q;
    assign scl_fall  = ~scl_f_q & scl_prev_q;
    assign start_det = scl_f_q & scl_prev_q & sda_prev_q & ~sda_f_q;
    assign stop_det  = scl_f_q & scl_prev_q & ~sda_prev_q & sda_f_q;

endmodule

// File: rtl/gt_touch_i2c_responder.sv
// I2C target emulating a GT-series touch controller (register map, point injection, INT).
// Define TP_INT_LEVEL_EN for a level INT held while status is ready; default is a pulsed INT.
module gt_touch_i2c_responder
    import gt_touch_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR  = 7'h14,
    parameter int          FILT_LEN  = 3,
    parameter logic [15:0] INT_PULSE = 16'd1000,
    parameter logic [31:0] PID_WORD  = 32'h37343139
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_o,
    output logic        sda_t,
    output logic        int_o,
    input  logic        tp_valid,
    input  logic        tp_press,
    input  logic [15:0] tp_x,
    input  logic [15:0] tp_y,
    output logic        busy
);
    logic sda_f, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_filt (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda_f    (sda_f),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        ack_act_q, ack_act_d, mack_q, mack_d, rw_q, rw_d;
    logic        sda_t_q, sda_t_d, busy_q, busy_d;
    logic [15:0] ptr_q, ptr_d;
    logic [7:0]  status_q, status_d, snap_status_q, snap_status_d;
    logic [15:0] x_q, x_d, y_q, y_d, snap_x_q, snap_x_d, snap_y_q, snap_y_d;
    logic [7:0]  rd_cur, rd_nxt, wr_byte;
    logic        wr_en;

    function automatic logic [7:0] reg_rd(input logic [15:0] a, input logic [7:0] st,
                                          input logic [15:0] x, input logic [15:0] y);
        logic [7:0] b;
        case (a)
            REG_PID0:            b = PID_WORD[7:0];
            REG_PID0 + 16'd1:    b = PID_WORD[15:8];
            REG_PID0 + 16'd2:    b = PID_WORD[23:16];
            REG_PID0 + 16'd3:    b = PID_WORD[31:24];
            REG_STATUS:          b = st;
            REG_P1_XL:           b = x[7:0];
            REG_P1_XL + 16'd1:   b = x[15:8];
            REG_P1_XL + 16'd2:   b = y[7:0];
            REG_P1_XL + 16'd3:   b = y[15:8];
            default:             b = 8'h00;
        endcase
        return b;
    endfunction

    // Reads come from the snapshot taken at the address ACK so a burst stays coherent.
    assign rd_cur  = reg_rd(ptr_q, snap_status_q, snap_x_q, snap_y_q);
    assign rd_nxt  = reg_rd(ptr_q + 16'd1, snap_status_q, snap_x_q, snap_y_q);
    assign wr_byte = {shreg_q[6:0], sda_f};

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        ack_act_d     = ack_act_q;
        mack_d        = mack_q;
        rw_d          = rw_q;
        ptr_d         = ptr_q;
        sda_t_d       = sda_t_q;
        busy_d        = busy_q;
        snap_status_d = snap_status_q;
        snap_x_d      = snap_x_q;
        snap_y_d      = snap_y_q;
        wr_en         = 1'b0;
        if (stop_det) begin
            state_d   = ST_IDLE;
            sda_t_d   = 1'b0;
            busy_d    = 1'b0;
            ack_act_d = 1'b0;
        end else if (start_det) begin
            state_d   = ST_DEV;
            bit_cnt_d = 3'd0;
            sda_t_d   = 1'b0;
            ack_act_d = 1'b0;
        end else begin
            case (state_q)
                ST_DEV, ST_AH, ST_AL, ST_WR: begin
                    if (scl_rise) begin
                        shreg_d   = wr_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        ack_act_d = 1'b0;
                        if (bit_cnt_q == 3'd7) begin
                            case (state_q)
                                ST_DEV: begin
                                    if (wr_byte[7:1] == DEV_ADDR) begin
                                        state_d       = ST_DEV_ACK;
                                        rw_d          = wr_byte[0];
                                        busy_d        = 1'b1;
                                        snap_status_d = status_q;
                                        snap_x_d      = x_q;
                                        snap_y_d      = y_q;
                                    end else begin
                                        state_d = ST_IDLE;
                                        busy_d  = 1'b0;
                                    end
                                end
                                ST_AH: begin
                                    ptr_d[15:8] = wr_byte;
                                    state_d     = ST_AH_ACK;
                                end
                                ST_AL: begin
                                    ptr_d[7:0] = wr_byte;
                                    state_d    = ST_AL_ACK;
                                end
                                default: begin
                                    wr_en   = 1'b1;
                                    ptr_d   = ptr_q + 16'd1;
                                    state_d = ST_WR_ACK;
                                end
                            endcase
                        end
                    end
                end
                ST_DEV_ACK, ST_AH_ACK, ST_AL_ACK, ST_WR_ACK: begin
                    // First SCL fall drives the ACK, the second one ends the ACK bit.
                    if (scl_fall) begin
                        if (!ack_act_q) begin
                            sda_t_d   = 1'b1;
                            ack_act_d = 1'b1;
                        end else begin
                            sda_t_d   = 1'b0;
                            ack_act_d = 1'b0;
                            bit_cnt_d = 3'd0;
                            case (state_q)
                                ST_DEV_ACK: begin
                                    if (rw_q) begin
                                        state_d = ST_RD;
                                        shreg_d = rd_cur;
                                        sda_t_d = ~rd_cur[7];
                                    end else begin
                                        state_d = ST_AH;
                                    end
                                end
                                ST_AH_ACK: state_d = ST_AL;
                                default:   state_d = ST_WR;
                            endcase
                        end
                    end
                end
                ST_RD: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d   = ST_RD_ACK;
                            ack_act_d = 1'b0;
                        end
                    end else if (scl_fall) begin
                        shreg_d = shreg_q << 1;
                        sda_t_d = ~shreg_q[6];
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise && ack_act_q) begin
                        mack_d = ~sda_f;
                    end else if (scl_fall) begin
                        if (!ack_act_q) begin
                            sda_t_d   = 1'b0;
                            ack_act_d = 1'b1;
                        end else begin
                            ack_act_d = 1'b0;
                            bit_cnt_d = 3'd0;
                            if (mack_q) begin
                                ptr_d   = ptr_q + 16'd1;
                                shreg_d = rd_nxt;
                                sda_t_d = ~rd_nxt[7];
                                state_d = ST_RD;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end

        // A touch sample in the same cycle as a status-clearing write keeps the status set.
        status_d = status_q;
        x_d      = x_q;
        y_d      = y_q;
        if (tp_valid) begin
            status_d               = 8'h00;
            status_d[STATUS_READY] = 1'b1;
            status_d[0]            = tp_press;
            x_d                    = tp_press ? tp_x : 16'h0000;
            y_d                    = tp_press ? tp_y : 16'h0000;
        end else if (wr_en && (ptr_q == REG_STATUS)) begin
            status_d = 8'h00;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 3'd0;
            shreg_q       <= 8'h00;
            ack_act_q     <= 1'b0;
            mack_q        <= 1'b0;
            rw_q          <= 1'b0;
            ptr_q         <= 16'h0000;
            sda_t_q       <= 1'b0;
            busy_q        <= 1'b0;
            status_q      <= 8'h00;
            x_q           <= 16'h0000;
            y_q           <= 16'h0000;
            snap_status_q <= 8'h00;
            snap_x_q      <= 16'h0000;
            snap_y_q      <= 16'h0000;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            ack_act_q     <= ack_act_d;
            mack_q        <= mack_d;
            rw_q          <= rw_d;
            ptr_q         <= ptr_d;
            sda_t_q       <= sda_t_d;
            busy_q        <= busy_d;
            status_q      <= status_d;
            x_q           <= x_d;
            y_q           <= y_d;
            snap_status_q <= snap_status_d;
            snap_x_q      <= snap_x_d;
            snap_y_q      <= snap_y_d;
        end
    end

`ifdef TP_INT_LEVEL_EN
    assign int_o = ~status_q[STATUS_READY];
`else
    logic [15:0] int_cnt_q, int_cnt_d;

    always_comb begin
        int_cnt_d = int_cnt_q;
        if (tp_valid)                int_cnt_d = INT_PULSE;
        else if (int_cnt_q != 16'd0) int_cnt_d = int_cnt_q - 16'd1;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) int_cnt_q <= 16'd0;
        else         int_cnt_q <= int_cnt_d;
    end

    assign int_o = (int_cnt_q == 16'd0);
`endif

    assign sda_o = 1'b0;
    assign sda_t = sda_t_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_gt_touch_i2c_responder.sv
// Bench for gt_touch_i2c_responder: bit-banged I2C master, register-map reference model,
// and a scoreboard that pairs expected values with bus observations in order.
module tb_gt_touch_i2c_responder;
    localparam int Q        = 8;
    localparam int EDGE_LAT = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_scl, m_low;
    logic        tp_valid, tp_press;
    logic [15:0] tp_x, tp_y;
    logic        sda_o, sda_t, int_o, busy;
    logic        sda_line;

    assign sda_line = ~(m_low | sda_t);
    always #5 clk = ~clk;

    gt_touch_i2c_responder dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .scl_i   (m_scl),
        .sda_i   (sda_line),
        .sda_o   (sda_o),
        .sda_t   (sda_t),
        .int_o   (int_o),
        .tp_valid(tp_valid),
        .tp_press(tp_press),
        .tp_x    (tp_x),
        .tp_y    (tp_y),
        .busy    (busy)
    );

    typedef struct {
        string name;
        int    val;
    } item_t;

    item_t exp_q[$];
    int    obs_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    logic [7:0]  m_status;
    logic [15:0] m_x, m_y;

    function automatic logic [7:0] m_rd(input logic [15:0] a);
        logic [31:0] pid;
        pid = 32'h37343139;
        case (a)
            16'h8140: return pid[7:0];
            16'h8141: return pid[15:8];
            16'h8142: return pid[23:16];
            16'h8143: return pid[31:24];
            16'h814E: return m_status;
            16'h8150: return m_x[7:0];
            16'h8151: return m_x[15:8];
            16'h8152: return m_y[7:0];
            16'h8153: return m_y[15:8];
            default:  return 8'h00;
        endcase
    endfunction

    function automatic void m_touch(input logic press, input logic [15:0] x, input logic [15:0] y);
        m_status = press ? 8'h81 : 8'h80;
        m_x      = press ? x : 16'h0000;
        m_y      = press ? y : 16'h0000;
    endfunction

    function automatic void m_reset();
        m_status = 8'h00;
        m_x      = 16'h0000;
        m_y      = 16'h0000;
    endfunction

    task automatic expect_v(input string name, input int val);
        item_t it;
        it.name = name;
        it.val  = val;
        exp_q.push_back(it);
    endtask

    task automatic observe(input int val);
        obs_q.push_back(val);
    endtask

    // Scoreboard monitor
    initial begin
        forever begin
            @(posedge clk);
            while (obs_q.size() > 0) begin
                item_t e;
                int    o;
                o = obs_q.pop_front();
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got 0x%0h, required nothing", o);
                end else begin
                    e = exp_q.pop_front();
                    if (o != e.val) begin
                        n_fail++;
                        $display("FAIL %s: got 0x%0h, required 0x%0h", e.name, o, e.val);
                    end
                end
            end
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_low = 1'b0; cyc(Q);
        m_scl = 1'b1; cyc(Q);
        m_low = 1'b1; cyc(Q);
        m_scl = 1'b0; cyc(Q);
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; cyc(Q);
        m_scl = 1'b1; cyc(Q);
        m_low = 1'b0; cyc(Q);
    endtask

    task automatic write_bit(input logic b, input logic inj);
        m_low = ~b; cyc(Q);
        m_scl = 1'b1;
        if (inj) begin
            cyc(EDGE_LAT);
            tp_valid = 1'b1; cyc(1);
            tp_valid = 1'b0; cyc(2*Q - EDGE_LAT - 1);
        end else begin
            cyc(2*Q);
        end
        m_scl = 1'b0; cyc(Q);
    endtask

    task automatic read_bit(output logic b);
        m_low = 1'b0; cyc(Q);
        m_scl = 1'b1; cyc(Q);
        b = sda_line; cyc(Q);
        m_scl = 1'b0; cyc(Q);
    endtask

    task automatic wb(input logic [7:0] d, input logic exp_ack, input logic inj);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i], inj && (i == 0));
        expect_v($sformatf("ack_%02h", d), exp_ack ? 0 : 1);
        read_bit(b);
        observe(b);
    endtask

    task automatic rbyte(input logic last);
        logic [7:0] d;
        logic       b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        observe(d);
        write_bit(last, 1'b0);
    endtask

    task automatic tp_inject(input logic press, input logic [15:0] x, input logic [15:0] y);
        tp_press = press; tp_x = x; tp_y = y;
        tp_valid = 1'b1; cyc(1);
        tp_valid = 1'b0;
        m_touch(press, x, y);
    endtask

    task automatic rd_txn(input logic [15:0] addr, input int n, input int inj_after);
        i2c_start();
        wb(8'h28, 1'b1, 1'b0);
        wb(addr[15:8], 1'b1, 1'b0);
        wb(addr[7:0], 1'b1, 1'b0);
        i2c_start();
        wb(8'h29, 1'b1, 1'b0);
        expect_v("busy_addressed", 1); observe(busy);
        for (int i = 0; i < n; i++)
            expect_v($sformatf("rd_%04h", addr + 16'(i)), m_rd(addr + 16'(i)));
        for (int i = 0; i < n; i++) begin
            rbyte(i == n - 1);
            if (i == inj_after)
                tp_inject(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
        end
        expect_v("sda_released_after_nack", 0); observe(sda_t);
        i2c_stop();
        cyc(Q);
        expect_v("busy_after_stop", 0); observe(busy);
    endtask

    task automatic wr_txn(input logic [15:0] addr, input logic [7:0] d, input logic inj);
        i2c_start();
        wb(8'h28, 1'b1, 1'b0);
        wb(addr[15:8], 1'b1, 1'b0);
        wb(addr[7:0], 1'b1, 1'b0);
        wb(d, 1'b1, inj);
        i2c_stop();
        cyc(Q);
        if (inj)                        m_touch(tp_press, tp_x, tp_y);
        else if (addr == 16'h814E)      m_status = 8'h00;
    endtask

    initial begin
        int cnt;
        logic b;
        rst = 1'b1; m_scl = 1'b1; m_low = 1'b0;
        tp_valid = 1'b0; tp_press = 1'b0; tp_x = 16'h0; tp_y = 16'h0;
        m_reset();
        cyc(4);
        expect_v("reset_sda_t", 0); observe(sda_t);
        expect_v("reset_int_o", 1); observe(int_o);
        expect_v("reset_busy", 0);  observe(busy);
        rst = 1'b0;
        cyc(Q);

        // Product ID via repeated START
        rd_txn(16'h8140, 4, -1);

        // Foreign address is NACKed and ignored
        i2c_start();
        wb(8'h2A, 1'b0, 1'b0);
        expect_v("busy_foreign", 0); observe(busy);
        wb(8'h00, 1'b0, 1'b0);
        expect_v("sda_t_foreign", 0); observe(sda_t);
        i2c_stop();

        // Touch press, INT behaviour and point readout
        tp_inject(1'b1, 16'h01E0, 16'h0110);
        cnt = 0;
        for (int i = 0; i < 1300; i++) begin
            if (!int_o) cnt++;
            cyc(1);
        end
`ifdef TP_INT_LEVEL_EN
        expect_v("int_low_cycles", 1300); observe(cnt);
`else
        expect_v("int_low_cycles", 1000); observe(cnt);
`endif
        rd_txn(16'h814E, 6, -1);

        // Status clear, then clear racing a new sample
        wr_txn(16'h814E, 8'h00, 1'b0);
        expect_v("int_o_after_clear", 1); observe(int_o);
        rd_txn(16'h814E, 1, -1);
        tp_press = 1'b1; tp_x = 16'($urandom); tp_y = 16'($urandom);
        wr_txn(16'h814E, 8'h5A, 1'b1);
        rd_txn(16'h814E, 6, -1);

        // Release sample
        tp_inject(1'b0, 16'h1234, 16'h5678);
        rd_txn(16'h814E, 6, -1);

        // Pointer wrap into unmapped space
        rd_txn(16'hFFFF, 2, -1);

        // Randomized samples and reads, some with a sample landing mid-burst
        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 1) == 1)
                tp_inject(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
            rd_txn(16'h813E + 16'($urandom_range(0, 23)), int'($urandom_range(1, 4)),
                   ($urandom_range(0, 2) == 0) ? 0 : -1);
        end

        // Reset while the target drives a read bit
        i2c_start();
        wb(8'h28, 1'b1, 1'b0);
        wb(8'h81, 1'b1, 1'b0);
        wb(8'h40, 1'b1, 1'b0);
        i2c_start();
        wb(8'h29, 1'b1, 1'b0);
        m_low = 1'b0; cyc(Q);
        m_scl = 1'b1; cyc(Q);
        expect_v("rd_bit_driven", 1); observe(sda_t);
        rst = 1'b1;
        #1;
        expect_v("sda_t_in_reset", 0); observe(sda_t);
        expect_v("busy_in_reset", 0);  observe(busy);
        cyc(3);
        rst = 1'b0;
        m_reset();
        cyc(Q);
        expect_v("int_o_after_reset", 1); observe(int_o);
        rd_txn(16'h8140, 4, -1);
        rd_txn(16'h814E, 6, -1);

        cyc(4);
        while (exp_q.size() > 0) begin
            item_t e;
            e = exp_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no output, required 0x%0h", e.name, e.val);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
